// File: rtl/inverter_pkg.sv
// -----------------------------------------------------------------------------
// inverter_pkg
// Shared definitions for the inverter PWM controller: FSM state encoding,
// fault cause codes, default carrier period and the center-aligned compare
// calculation used by the top level.
// -----------------------------------------------------------------------------
package inverter_pkg;

  localparam logic [15:0] DEF_PERIOD = 16'd5000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } pwm_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_EXT  = 2'd1,
    CAUSE_WDOG = 2'd2
  } fault_cause_e;

  // Compare pair handed to the power leg.
  typedef struct packed {
    logic [15:0] t1;
    logic [15:0] t2;
  } cmp_pair_t;

  // Center-aligned on-window [t1, t2) for a given on-time; 17-bit intermediates.
  function automatic cmp_pair_t calc_cmp(input logic [15:0] period,
                                         input logic [15:0] duty);
    cmp_pair_t r;
    r.t1 = 16'((17'(period) - 17'(duty)) >> 1);
    r.t2 = 16'(17'(r.t1) + 17'(duty));
    return r;
  endfunction

endpackage

// File: rtl/pwm_carrier_cnt.sv
// -----------------------------------------------------------------------------
// pwm_carrier_cnt
// Free-running carrier counter 0..PERIOD-1 with a registered period_tick that
// is high exactly while the counter reads PERIOD-1.
// Ports:
//   sysclk, global_rst  clock / async active-low reset
//   cnt                 carrier counter (16 bit)
//   period_tick         one-cycle pulse coincident with cnt == PERIOD-1
// -----------------------------------------------------------------------------
module pwm_carrier_cnt
  import inverter_pkg::*;
#(
  parameter logic [15:0] PERIOD = DEF_PERIOD
) (
  input  logic        sysclk,
  input  logic        global_rst,
  output logic [15:0] cnt,
  output logic        period_tick
);

  logic [15:0] cnt_nxt_c;

  // Wrap at PERIOD-1.
  always_comb begin
    cnt_nxt_c = (cnt == PERIOD - 16'd1) ? 16'd0 : cnt + 16'd1;
  end

  // Tick is registered from the next count so it aligns with cnt == PERIOD-1.
  always_ff @(posedge sysclk or negedge global_rst) begin
    if (!global_rst) begin
      cnt         <= 16'd0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt_c;
      period_tick <= (cnt_nxt_c == PERIOD - 16'd1);
    end
  end

endmodule

// File: rtl/inverter_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// inverter_pwm_ctrl
// Single-leg inverter PWM controller: carrier, IDLE/BOOT/RUN/FAULT sequencing,
// duty command handshake and center-aligned compare generation.
// Optional build macro: INVERTER_PWM_WDOG_EN adds a command watchdog that
// faults the leg after WDOG_PERIODS RUN periods without an accepted command.
// Ports:
//   sysclk, global_rst       clock / async active-low reset
//   en                       1 = run request, 0 = stop
//   fault_n                  active-low external fault (already synchronised)
//   fault_clr                single-cycle fault acknowledge
//   cmd_valid/cmd_duty       duty command (on-time in sysclk cycles)
//   cmd_ready                command slot free
//   global_cnt_rising        carrier counter to the leg
//   T1, T2                   leg turn-on / turn-off compares
//   SD                       leg enable (0 = shut down)
//   period_tick              pulse while counter = PERIOD-1
//   state, fault_cause       status
// -----------------------------------------------------------------------------
module inverter_pwm_ctrl
  import inverter_pkg::*;
#(
  parameter logic [15:0]  PERIOD       = DEF_PERIOD,
  parameter logic [15:0]  MAX_DUTY     = 16'd4900,
  parameter int unsigned  BOOT_PERIODS = 8,
  parameter int unsigned  WDOG_PERIODS = 16
) (
  input  logic        sysclk,
  input  logic        global_rst,
  input  logic        en,
  input  logic        fault_n,
  input  logic        fault_clr,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_duty,
  output logic        cmd_ready,
  output logic [15:0] global_cnt_rising,
  output logic [15:0] T1,
  output logic [15:0] T2,
  output logic        SD,
  output logic        period_tick,
  output logic [1:0]  state,
  output logic [1:0]  fault_cause
);

  localparam int unsigned BOOT_W = (BOOT_PERIODS > 1) ? $clog2(BOOT_PERIODS) : 1;

  pwm_state_e   cur_st;
  fault_cause_e cause_q;
  logic [BOOT_W-1:0] boot_cnt;
  logic        pend_valid;
  logic [15:0] pend_duty;
  logic [15:0] duty;

  logic        accept_c;
  logic        last_boot_c;
  logic [15:0] clamp_duty_c;
  logic [15:0] eff_duty_c;
  cmp_pair_t   cmp_c;

  assign state       = cur_st;
  assign fault_cause = cause_q;

  pwm_carrier_cnt #(
    .PERIOD (PERIOD)
  ) u_carrier (
    .sysclk      (sysclk),
    .global_rst  (global_rst),
    .cnt         (global_cnt_rising),
    .period_tick (period_tick)
  );

  // Handshake and compare math; a pending command overrides the held duty.
  always_comb begin
    accept_c     = cmd_valid && cmd_ready;
    clamp_duty_c = (cmd_duty > MAX_DUTY) ? MAX_DUTY : cmd_duty;
    eff_duty_c   = pend_valid ? pend_duty : duty;
    cmp_c        = calc_cmp(PERIOD, eff_duty_c);
    last_boot_c  = (boot_cnt == BOOT_W'(BOOT_PERIODS - 1));
  end

`ifdef INVERTER_PWM_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_PERIODS > 1) ? $clog2(WDOG_PERIODS) : 1;

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_expire_c;

  assign wdog_expire_c = (cur_st == ST_RUN) && period_tick && !accept_c &&
                         (wdog_cnt == WDOG_W'(WDOG_PERIODS - 1));

  // Counts RUN period ticks since the last accepted command.
  always_ff @(posedge sysclk or negedge global_rst) begin
    if (!global_rst) begin
      wdog_cnt <= '0;
    end else if ((cur_st != ST_RUN) || accept_c) begin
      wdog_cnt <= '0;
    end else if (period_tick) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_PERIODS;
`endif

  // Sequencer with registered leg outputs; external fault wins over everything.
  always_ff @(posedge sysclk or negedge global_rst) begin
    if (!global_rst) begin
      cur_st     <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      SD         <= 1'b0;
      T1         <= PERIOD;
      T2         <= 16'd0;
      cmd_ready  <= 1'b0;
      pend_valid <= 1'b0;
      pend_duty  <= 16'd0;
      duty       <= 16'd0;
      boot_cnt   <= '0;
    end else if (!fault_n) begin
      cur_st     <= ST_FAULT;
      cause_q    <= CAUSE_EXT;
      SD         <= 1'b0;
      T1         <= PERIOD;
      T2         <= 16'd0;
      cmd_ready  <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      case (cur_st)
        ST_IDLE: begin
          if (period_tick && en) begin
            cur_st    <= ST_BOOT;
            boot_cnt  <= '0;
            SD        <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end
        ST_BOOT, ST_RUN: begin
          if (!en) begin
            cur_st     <= ST_IDLE;
            SD         <= 1'b0;
            T1         <= PERIOD;
            T2         <= 16'd0;
            cmd_ready  <= 1'b0;
            pend_valid <= 1'b0;
          end
`ifdef INVERTER_PWM_WDOG_EN
          else if (wdog_expire_c) begin
            cur_st     <= ST_FAULT;
            cause_q    <= CAUSE_WDOG;
            SD         <= 1'b0;
            T1         <= PERIOD;
            T2         <= 16'd0;
            cmd_ready  <= 1'b0;
            pend_valid <= 1'b0;
          end
`endif
          else begin
            if (period_tick) begin
              // BOOT keeps T1/T2 parked until its last tick, which loads RUN compares.
              if ((cur_st == ST_RUN) || last_boot_c) begin
                cur_st     <= ST_RUN;
                T1         <= cmp_c.t1;
                T2         <= cmp_c.t2;
                duty       <= eff_duty_c;
                pend_valid <= 1'b0;
                cmd_ready  <= 1'b1;
              end else begin
                boot_cnt <= boot_cnt + BOOT_W'(1);
              end
            end
            // cmd_ready implies no pending, so accept never collides with consume.
            if (accept_c) begin
              pend_valid <= 1'b1;
              pend_duty  <= clamp_duty_c;
              cmd_ready  <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            cur_st  <= ST_IDLE;
            cause_q <= CAUSE_NONE;
          end
        end
      endcase
    end
  end

endmodule
